// File: rtl/crypt3_pkg.sv
// Shared types and constants for the crypt(3) key path: key geometry,
// loader FSM states and the FIFO entry layout.
package crypt3_pkg;

    localparam int KEY_CHARS = 8;
    localparam int CHAR_BITS = 7;
    localparam int KEY_BITS  = 56;

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        PUSH
    } loader_state_t;

    typedef struct packed {
        logic [KEY_BITS-1:0] key;
        logic [3:0]          len;
        logic                trunc;
    } key_entry_t;

endpackage

// File: rtl/crypt3_key_fifo.sv
// Small synchronous FIFO of packed keys; the head is read straight from the
// entry registers, so it stays stable until popped.
module crypt3_key_fifo
    import crypt3_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       wr_en,
    input  key_entry_t wr_data,
    input  logic       rd_en,
    output key_entry_t rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    key_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/crypt3_key_loader.sv
// Packs a streamed candidate word into a 56-bit crypt(3) DES key (7 bits per
// char, max 8 chars, NUL-terminated, zero-padded) and queues it for the DES core.
module crypt3_key_loader
    import crypt3_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [KEY_BITS-1:0]  key_out,
    output logic [3:0]           key_len,
    output logic                 key_trunc,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [CNT_WIDTH-1:0] key_cnt
);
    localparam logic [3:0] IDX_FULL = 4'(KEY_CHARS);

    loader_state_t        state, state_nx;
    logic [KEY_BITS-1:0]  pack, pack_nx;
    logic [3:0]           idx, idx_nx;
    logic                 trunc, trunc_nx;
    logic                 ready_q;
    logic                 in_xfer;
    logic                 nul;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 char_msb_unused;
    logic [CNT_WIDTH-1:0] cnt;
    key_entry_t           wr_entry;
    key_entry_t           head;

    assign char_msb_unused = in_data[7];
    assign in_ready  = ready_q;
    assign in_xfer   = in_valid && ready_q;
    assign nul       = (in_data[6:0] == 7'd0);
    assign key_valid = !fifo_empty;
    assign pop       = key_valid && key_ready;
    assign wr_entry  = '{key: pack, len: idx, trunc: trunc};
    assign key_out   = head.key;
    assign key_len   = head.len;
    assign key_trunc = head.trunc;
    assign key_cnt   = cnt;

    always_comb begin
        state_nx = state;
        pack_nx  = pack;
        idx_nx   = idx;
        trunc_nx = trunc;
        push     = 1'b0;
        case (state)
            COLLECT: begin
                if (in_xfer) begin
                    if (nul) begin
                        // A NUL ends the key; anything after it is just drained.
                        trunc_nx = !in_last;
                        state_nx = in_last ? PUSH : DRAIN;
                    end else begin
                        if (idx < IDX_FULL) begin
                            pack_nx[CHAR_BITS*int'(idx[2:0]) +: CHAR_BITS] = in_data[6:0];
                            idx_nx = idx + 4'd1;
                        end else begin
                            trunc_nx = 1'b1;
                        end
                        if (in_last) begin
                            state_nx = PUSH;
                        end else if (idx == IDX_FULL) begin
                            state_nx = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (in_xfer && in_last) begin
                    state_nx = PUSH;
                end
            end
            PUSH: begin
                push = !fifo_full || pop;
                if (push) begin
                    state_nx = COLLECT;
                    pack_nx  = '0;
                    idx_nx   = '0;
                    trunc_nx = 1'b0;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= COLLECT;
            pack    <= '0;
            idx     <= '0;
            trunc   <= 1'b0;
            ready_q <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            pack    <= pack_nx;
            idx     <= idx_nx;
            trunc   <= trunc_nx;
            ready_q <= (state_nx != PUSH);
            if (push) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    crypt3_key_fifo #(
        .DEPTH(OUT_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .wr_en  (push),
        .wr_data(wr_entry),
        .rd_en  (key_ready),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: doc/crypt3_key_loader.md
Name: crypt3_key_loader

Overview:
- Streams candidate-password characters from the word generator (8-bit valid/ready, with a last flag).
- Packs up to 8 characters into the 56-bit, 7-bit-per-character key word consumed by crypt3_ascii2bin and the DES key schedule (PC1).
- Applies crypt(3) key rules: bit 7 of every character is dropped, the key is truncated at 8 characters or at the first NUL, and short keys are zero-padded.
- A small output FIFO decouples loading of key N+1 from DES core consumption of key N.

Parameters:
- OUT_DEPTH, 2, entries in the output key FIFO; power of two, at least 2.
- CNT_WIDTH, 16, width of the packed-key counter.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- in_data  in  8  ASCII character.
- in_valid  in  1  in_data is valid.
- in_last  in  1  this character is the final one of the word.
- in_ready  out  1  loader accepts a character this cycle.
- key_out  out  56  packed key: din[7i+k] = char_i[k], i=0 is the first character.
- key_len  out  4  effective key length, 0..8.
- key_trunc  out  1  word was longer than 8 characters or contained a NUL before in_last.
- key_valid  out  1  FIFO head is valid.
- key_ready  in  1  DES core takes the head.
- key_cnt  out  CNT_WIDTH  number of keys pushed into the FIFO; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State is COLLECT; char index idx=0; pack register=0.
  - FIFO empty; key_valid=0; key_out=0; key_len=0; key_trunc=0; key_cnt=0.
  - in_ready=0 while RST_N=0; in_ready=1 on the first cycle after release.
- Input transfer happens when in_valid && in_ready. Output transfer happens when key_valid && key_ready.
- COLLECT:
  - On a transfer with in_data[6:0]!=0 and idx<8: write pack[7*idx+:7] = in_data[6:0], then idx++.
  - in_data==0x00 or 0x80 (NUL after masking): terminates the key. Set the NUL-seen flag. If !in_last, go to DRAIN.
  - Transfer with in_last: go to PUSH.
  - 9th accepted character (idx==8) without in_last: set the trunc flag, go to DRAIN.
  - 8th character with in_last=1: go to PUSH with trunc=0.
- DRAIN:
  - in_ready=1; characters are discarded.
  - A transfer with in_last goes to PUSH.
  - The word that caused truncation is always fully consumed before the next word starts.
- PUSH:
  - in_ready=0.
  - If the FIFO is not full: write {pack, idx, trunc} and increment key_cnt. Next cycle: clear pack, idx and flags, go to COLLECT.
  - If the FIFO is full: stay in PUSH (backpressure).
  - A simultaneous pop in the same cycle frees a slot. The push proceeds in that cycle (full && pop is treated as not full).
- Latency:
  - Last input character to key_valid (FIFO empty) is 2 cycles: PUSH cycle, then registered FIFO head.
  - Sustained throughput is one key per (word length + 1) cycles.
- in_ready is registered-state derived: 1 in COLLECT/DRAIN, 0 in PUSH. It has no combinational path from key_ready.
- in_last on the first character with a NUL gives key_len=0 and key_out=0. This is a legal key and is pushed.
- FIFO:
  - Registered outputs; key_out/key_len/key_trunc hold stable while key_valid && !key_ready.
  - Pointers wrap modulo OUT_DEPTH; full/empty are distinguished by an extra pointer bit.
- Reset asserted mid-word: the partial word is lost and FIFO contents are discarded. The upstream generator is required to restart the word.

Decomposition:
- Shared package crypt3_pkg:
  - constants KEY_CHARS=8, CHAR_BITS=7, KEY_BITS=56.
  - enum loader_state_t {COLLECT, DRAIN, PUSH}.
  - struct key_entry_t {key[55:0], len[3:0], trunc}.
- Sub-module crypt3_key_fifo: synchronous FIFO of key_entry_t, depth OUT_DEPTH, registered head, async active-low reset. The loader FSM and packer stay in the top module.

Test Plan:
- Word "abc" (0x61,0x62,0x63, in_last on 0x63), key_ready=1 -> key_out[6:0]=0x61, [13:7]=0x62, [20:14]=0x63, rest 0; key_len=3; key_trunc=0; key_valid 2 cycles after the 0x63 transfer; key_cnt=1.
- Word "password1" (9 chars) -> key_len=8; key_out holds "password"; key_trunc=1; '1' discarded; in_ready stays 1 through the drain.
- Word 0xE1,0x00,0x62,last -> key_out[6:0]=0x61 with bit 7 stripped; key_len=1; key_trunc=1; 0x62 ignored.
- key_ready=0, three 2-char words sent back-to-back -> two keys buffered; in_ready=0 in PUSH of the third word until key_ready pulses once; order preserved; key_cnt=3 at the end.
- Single char 0x00 with in_last -> key_valid with key_len=0, key_out=0, key_trunc=0.
- RST_N pulled low after 4 chars of a word while the FIFO holds 1 key -> key_valid=0 immediately (asynchronous), key_cnt=0; next word "xy" after release -> key_len=2, correct packing.
